// File: rtl/tx_port_arbiter.sv
// Round-robin arbiter sharing one serial tx port (txdata/txclk/txready) among N byte requesters.
// Optional build macro TX_ARB_PRIO_EN gives requester 0 strict priority without moving the pointer.
module tx_port_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned STROBE_LEN = 1,
  parameter int unsigned GAP_CYC    = 4
) (
  input  logic                 hz100,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [8*N-1:0]       req_data,
  output logic [N-1:0]         ack,
  input  logic                 txready,
  output logic [7:0]           txdata,
  output logic                 txclk,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned SCntW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
  localparam int unsigned GCntW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [SCntW-1:0] StrobeLast = SCntW'(STROBE_LEN - 1);
  localparam logic [GCntW-1:0] GapLast    = GCntW'(GAP_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDrain} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [SCntW-1:0]  scnt_q, scnt_d;
  logic [GCntW-1:0]  gcnt_q, gcnt_d;
  logic [7:0]        txdata_q, txdata_d;
  logic              txclk_q, txclk_d;
  logic              busy_q, busy_d;
  logic [N-1:0]      ack_q, ack_d;
  logic [IdxW-1:0]   grant_q, grant_d;

  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   ptr_next;
  logic [7:0]        win_byte;
  logic              grant;

  assign grant = (state_q == StIdle) && txready && (|req);

  // Scan downward so the last hit is the first set bit at or after ptr (mod N).
  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] idx_w;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = 32'(ptr_q) + 32'(i);
      if (idx >= N) idx = idx - N;
      idx_w = IdxW'(idx);
      if (req[idx_w]) winner = idx_w;
    end
`ifdef TX_ARB_PRIO_EN
    if (req[0]) winner = '0;
`endif
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IdxW'(i)) win_byte = req_data[8*i +: 8];
    end
  end

  assign ptr_next = (winner == IdxW'(N - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      scnt_q   <= '0;
      gcnt_q   <= '0;
      txdata_q <= '0;
      txclk_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      scnt_q   <= scnt_d;
      gcnt_q   <= gcnt_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StSend;
      StSend:  if (scnt_q == StrobeLast) state_d = StDrain;
      StDrain: if (!txready || gcnt_q == GapLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    scnt_d   = scnt_q;
    gcnt_d   = gcnt_q;
    txdata_d = txdata_q;
    txclk_d  = txclk_q;
    ack_d    = '0;
    grant_d  = grant_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          txdata_d      = win_byte;
          txclk_d       = 1'b1;
          ack_d[winner] = 1'b1;
          grant_d       = winner;
          scnt_d        = '0;
`ifdef TX_ARB_PRIO_EN
          if (!req[0]) ptr_d = ptr_next;
`else
          ptr_d = ptr_next;
`endif
        end
      end
      StSend: begin
        if (scnt_q == StrobeLast) begin
          txclk_d = 1'b0;
          gcnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (txready && gcnt_q != GapLast) gcnt_d = gcnt_q + 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  assign ack      = ack_q;
  assign txdata   = txdata_q;
  assign txclk    = txclk_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Directed bench for tx_port_arbiter: one instance with STROBE_LEN=1, one with STROBE_LEN=3.
module tb_tx_port_arbiter;

  logic        hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  logic        reset, txready, txclk, busy;
  logic [3:0]  req, ack;
  logic [31:0] req_data;
  logic [7:0]  txdata;
  logic [1:0]  grant_id;

  logic        reset3, txready3, txclk3, busy3;
  logic [3:0]  req3, ack3;
  logic [31:0] req_data3;
  logic [7:0]  txdata3;
  logic [1:0]  grant_id3;

  int n_checks = 0;
  int n_errors = 0;

  tx_port_arbiter #(.N(4), .STROBE_LEN(1), .GAP_CYC(4)) dut (
    .hz100    (hz100),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .txready  (txready),
    .txdata   (txdata),
    .txclk    (txclk),
    .busy     (busy),
    .grant_id (grant_id)
  );

  tx_port_arbiter #(.N(4), .STROBE_LEN(3), .GAP_CYC(4)) dut3 (
    .hz100    (hz100),
    .reset    (reset3),
    .req      (req3),
    .req_data (req_data3),
    .ack      (ack3),
    .txready  (txready3),
    .txdata   (txdata3),
    .txclk    (txclk3),
    .busy     (busy3),
    .grant_id (grant_id3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int cnt = 0;
    while (busy !== 1'b0 && cnt < 20) begin
      tick();
      cnt++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  int rr_order[5] = '{0, 1, 2, 3, 0};
  int cnt;
  int exp_prio;

  initial begin
    reset = 1'b1; txready = 1'b0; req = '0; req_data = '0;
    reset3 = 1'b1; txready3 = 1'b0; req3 = '0; req_data3 = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_txclk", 32'(txclk), 32'd0);
    check("rst_txdata", 32'(txdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);

    // Single request
    txready = 1'b1; req = 4'b0001; req_data = 32'h0000_0041;
    tick();
    check("single_txclk", 32'(txclk), 32'd1);
    check("single_txdata", 32'(txdata), 32'h41);
    check("single_ack", 32'(ack), 32'b0001);
    check("single_grant", 32'(grant_id), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    req = '0;
    tick();
    check("single_txclk_low", 32'(txclk), 32'd0);
    check("single_ack_low", 32'(ack), 32'd0);
    check("single_hold", 32'(txdata), 32'h41);
    tick(); tick(); tick();
    check("gap_busy_still", 32'(busy), 32'd1);
    tick();
    check("gap_busy_end", 32'(busy), 32'd0);

    // Round-robin fairness from ptr=0
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; req_data = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (ack == 4'b0 && cnt < 20);
      check("rr_ack", 32'(ack), 32'(4'b0001 << rr_order[k]));
      check("rr_grant", 32'(grant_id), 32'(rr_order[k]));
      check("rr_txdata", 32'(txdata), 32'(8'h10 + rr_order[k]));
      check("rr_spacing", 32'(cnt), (k == 0) ? 32'd1 : 32'd6);
    end
    req = '0;
    wait_idle("rr_idle");

    // Backpressure (ptr=1)
    txready = 1'b0; req = 4'b0100; req_data = 32'h005A_0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_ack", 32'(ack), 32'd0);
      check("bp_txclk", 32'(txclk), 32'd0);
    end
    txready = 1'b1;
    tick();
    check("bp_ack_grant", 32'(ack), 32'b0100);
    check("bp_grant", 32'(grant_id), 32'd2);
    check("bp_txdata", 32'(txdata), 32'h5A);
    req = '0;

    // Drain early exit (ptr=3)
    tick();
    check("drain_txclk", 32'(txclk), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    txready = 1'b0; req = 4'b0010; req_data = 32'h005A_7700;
    tick();
    check("drain_exit", 32'(busy), 32'd0);
    tick();
    check("drain_nogrant", 32'(ack), 32'd0);
    txready = 1'b1;
    tick();
    check("drain_ack", 32'(ack), 32'b0010);
    check("drain_grant", 32'(grant_id), 32'd1);
    check("drain_txdata", 32'(txdata), 32'h77);
    req = '0;
    wait_idle("drain_idle");

    // ptr=2, req 0 and 2 both pending
`ifdef TX_ARB_PRIO_EN
    exp_prio = 0;
`else
    exp_prio = 2;
`endif
    req = 4'b0101; req_data = 32'h00A2_00A0;
    tick();
    check("prio_grant", 32'(grant_id), 32'(exp_prio));
    check("prio_txdata", 32'(txdata), 32'(8'hA0 + exp_prio));
    req = '0;
    wait_idle("prio_idle");
    req = 4'b0100;
    tick();
    check("prio_next_ack", 32'(ack), 32'b0100);
    check("prio_next_grant", 32'(grant_id), 32'd2);
    req = '0;
    wait_idle("prio_next_idle");

    // Reset mid-SEND on the STROBE_LEN=3 instance
    reset3 = 1'b0; txready3 = 1'b1; req3 = 4'b0010; req_data3 = 32'h0000_3300;
    tick();
    check("r3_ack", 32'(ack3), 32'b0010);
    check("r3_txclk", 32'(txclk3), 32'd1);
    req3 = '0;
    tick();
    check("r3_send2_txclk", 32'(txclk3), 32'd1);
    check("r3_send2_ack", 32'(ack3), 32'd0);
    reset3 = 1'b1;
    tick();
    reset3 = 1'b0;
    check("r3_rst_txclk", 32'(txclk3), 32'd0);
    check("r3_rst_ack", 32'(ack3), 32'd0);
    check("r3_rst_txdata", 32'(txdata3), 32'd0);
    check("r3_rst_busy", 32'(busy3), 32'd0);
    check("r3_rst_grant", 32'(grant_id3), 32'd0);
    tick();
    check("r3_no_reack", 32'(ack3), 32'd0);
    req3 = 4'b0110; req_data3 = 32'h0022_1100;
    tick();
    check("r3_ptr0_ack", 32'(ack3), 32'b0010);
    check("r3_ptr0_grant", 32'(grant_id3), 32'd1);
    req3 = '0;
    tick();
    check("r3_strobe2", 32'(txclk3), 32'd1);
    tick();
    check("r3_strobe3", 32'(txclk3), 32'd1);
    tick();
    check("r3_strobe_end", 32'(txclk3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
